keypad_event_encoder: RTL

Converts the 12 debounced keypad level outputs from the keypad scanner into a stream of discrete key events (press, release, auto-repeat), each carrying a 4-bit key code. Sits directly downstream of the keypad scanner/debounce stage and feeds the simulator control logic (gear, throttle, menu) through a valid/ready FIFO. Simultaneous edges are never lost: they are held pending and serialized by priority.

---
 rtl/keypad_event_encoder.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_event_encoder.sv
// keypad_event_encoder: turns 12 debounced key levels into press/release events queued in a small FIFO.
// Define KEY_REPEAT_EN to add the auto-repeat timer (kind 10 events); without it REPEAT_* are ignored.
module keypad_event_encoder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_lvl,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic [1:0]  evt_kind,
    output logic        key_held,
    output logic [3:0]  held_code
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] KIND_PRESS   = 2'b00;
    localparam logic [1:0] KIND_RELEASE = 2'b01;

    function automatic logic [3:0] lowest_index(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // ---------------------------------------------------------------
    // Edge detection and pending event bits
    // ---------------------------------------------------------------
    logic [11:0] prev;
    logic [11:0] rise;
    logic [11:0] fall;
    logic [11:0] press_pend;
    logic [11:0] rel_pend;
    logic [11:0] any_pend;
    logic [11:0] sel_oh;
    logic [3:0]  sel_code;
    logic [11:0] press_clr;
    logic [11:0] rel_clr;

    assign rise     = key_lvl & ~prev;
    assign fall     = ~key_lvl & prev;
    assign any_pend = press_pend | rel_pend;
    // Isolate the lowest set bit: the key index that wins issue this cycle.
    assign sel_oh   = any_pend & (~any_pend + 12'd1);
    assign sel_code = lowest_index(any_pend);

    // ---------------------------------------------------------------
    // Repeat tracking (tracked key is kept in both builds for held_code)
    // ---------------------------------------------------------------
    logic       track_valid;
    logic [3:0] track_code;
    logic       track_fall;

    assign track_fall = track_valid && fall[track_code];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            track_valid <= 1'b0;
            track_code  <= 4'd0;
        end else if (|rise) begin
            track_valid <= 1'b1;
            track_code  <= lowest_index(rise);
        end else if (track_fall) begin
            track_valid <= 1'b0;
        end
    end

    assign key_held  = |prev;
    assign held_code = track_valid ? track_code : lowest_index(prev);

`ifdef KEY_REPEAT_EN
    localparam logic [1:0] KIND_REPEAT = 2'b10;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_in_rate;
    logic             rep_pend;
    logic             rep_clr;
    logic             rep_fire;
    logic             rep_drop;

    // Any new rise retargets and a release of the tracked key stops it;
    // either way a not-yet-issued repeat belongs to the old key and is dropped.
    assign rep_drop = (|rise) || track_fall;
    assign rep_fire = track_valid && !rep_drop &&
                      (rep_cnt == (rep_in_rate ? RATE_LAST : DELAY_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt     <= '0;
            rep_in_rate <= 1'b0;
            rep_pend    <= 1'b0;
        end else begin
            if (rep_drop) begin
                rep_cnt     <= '0;
                rep_in_rate <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt     <= '0;
                rep_in_rate <= 1'b1;
            end else if (track_valid) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
            rep_pend <= !rep_drop && (rep_fire || (rep_pend && !rep_clr));
        end
    end
`endif

    // ---------------------------------------------------------------
    // Issue selection: one push per cycle, lowest key first, press before
    // release, repeat only when no press/release is waiting.
    // ---------------------------------------------------------------
    logic       push;
    logic [5:0] push_data;
    logic       fifo_full;

    always_comb begin
        push      = 1'b0;
        push_data = 6'd0;
        press_clr = '0;
        rel_clr   = '0;
`ifdef KEY_REPEAT_EN
        rep_clr   = 1'b0;
`endif
        if (!fifo_full) begin
            if (|any_pend) begin
                push = 1'b1;
                if (|(press_pend & sel_oh)) begin
                    press_clr = sel_oh;
                    push_data = {KIND_PRESS, sel_code};
                end else begin
                    rel_clr   = sel_oh;
                    push_data = {KIND_RELEASE, sel_code};
                end
            end
`ifdef KEY_REPEAT_EN
            else if (rep_pend) begin
                push      = 1'b1;
                push_data = {KIND_REPEAT, track_code};
                rep_clr   = 1'b1;
            end
`endif
        end
    end

    // A new edge on a bit being issued this cycle re-arms it (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev       <= '0;
            press_pend <= '0;
            rel_pend   <= '0;
        end else begin
            prev       <= key_lvl;
            press_pend <= (press_pend & ~press_clr) | rise;
            rel_pend   <= (rel_pend & ~rel_clr) | fall;
        end
    end

    // ---------------------------------------------------------------
    // Event FIFO.
    // Handshake: evt_valid means the head entry is meaningful and stays
    // stable until taken; an entry is consumed on a clock edge where
    // evt_valid && evt_ready. Fullness is judged at the start of the cycle,
    // so a pop never frees room for a push in the same cycle.
    // ---------------------------------------------------------------
    logic [5:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             pop;

    assign fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign evt_valid = (fifo_cnt != '0);
    assign pop       = evt_valid && evt_ready;
    assign {evt_kind, evt_code} = evt_valid ? fifo_mem[rd_ptr] : 6'd0;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule
